// File: rtl/dsp_pkg.sv
// Shared types and constants for the effects-chain sample sequencer.
package dsp_pkg;

    localparam int unsigned SAMPLE_W     = 24;
    localparam int unsigned MULT_W       = 32;
    localparam int unsigned PROD_W       = 64;
    localparam int unsigned MULT_LATENCY = 2;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [MULT_W-1:0]   mult_op_t;
    typedef logic signed [PROD_W-1:0]   mult_prod_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } seq_state_t;

endpackage

// File: rtl/shared_mult.sv
// Two-stage pipelined signed 32x32 multiplier shared by all DSP stages.
module shared_mult
    import dsp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  mult_op_t   a,
    input  mult_op_t   b,
    output mult_prod_t p
);

    mult_op_t a_r;
    mult_op_t b_r;

    // Operand register then product register; runs every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r <= '0;
            b_r <= '0;
            p   <= '0;
        end else begin
            a_r <= a;
            b_r <= b;
            p   <= mult_prod_t'(a_r) * mult_prod_t'(b_r);
        end
    end

endmodule

// File: rtl/dsp_sequencer.sv
// Per-sample sequencer: runs the DSP stage chain and owns the shared multiplier.
// Optional stage watchdog enabled by defining DSP_SEQ_WATCHDOG_EN.
module dsp_sequencer
    import dsp_pkg::*;
#(
    parameter int unsigned N_STAGES = 4,
    parameter int unsigned TIMEOUT  = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_tick,
    input  logic [SAMPLE_W-1:0]          sample_in,
    input  logic [N_STAGES-1:0]          bypass,
    output logic [SAMPLE_W-1:0]          sample_out,
    output logic                         sample_valid,
    output logic                         busy,
    output logic                         overrun,
    output logic                         fault,
    output logic [N_STAGES-1:0]          stage_start,
    input  logic [N_STAGES-1:0]          stage_finish,
    output logic [SAMPLE_W-1:0]          stage_in,
    input  logic [N_STAGES*SAMPLE_W-1:0] stage_out,
    input  logic [N_STAGES*MULT_W-1:0]   stage_mult_a,
    input  logic [N_STAGES*MULT_W-1:0]   stage_mult_b,
    output logic [PROD_W-1:0]            mult_p
);

    localparam int unsigned IDX_W = $clog2(N_STAGES + 1);

    if (N_STAGES < 1 || TIMEOUT < 1) begin : g_param_check
        $error("dsp_sequencer: N_STAGES and TIMEOUT must be at least 1");
    end

    seq_state_t          state, state_nx;
    logic [IDX_W-1:0]    idx, idx_nx;
    sample_t             acc, acc_nx;
    logic [N_STAGES-1:0] skip, skip_nx;
    sample_t             out_nx;
    logic                valid_nx;
    logic                overrun_nx;
    logic [IDX_W-1:0]    first_c, adv_c;
    logic                cur_fin, timeout_c;
    sample_t             cur_out;
    mult_op_t            cur_a, cur_b, mult_a, mult_b;

    // Lowest enabled stage at or above lo; N_STAGES means none left.
    function automatic logic [IDX_W-1:0] next_stage(input logic [N_STAGES-1:0] skip_mask,
                                                    input int lo);
        next_stage = IDX_W'(N_STAGES);
        for (int i = int'(N_STAGES) - 1; i >= 0; i--) begin
            if (i >= lo && !skip_mask[i]) next_stage = IDX_W'(i);
        end
    endfunction

    // Select the active stage's finish, result and multiplier operands.
    always_comb begin
        cur_fin = 1'b0;
        cur_out = '0;
        cur_a   = '0;
        cur_b   = '0;
        for (int i = 0; i < int'(N_STAGES); i++) begin
            if (idx == IDX_W'(i)) begin
                cur_fin = stage_finish[i];
                cur_out = sample_t'(stage_out[i*SAMPLE_W +: SAMPLE_W]);
                cur_a   = mult_op_t'(stage_mult_a[i*MULT_W +: MULT_W]);
                cur_b   = mult_op_t'(stage_mult_b[i*MULT_W +: MULT_W]);
            end
        end
    end

    always_comb begin
        stage_start = '0;
        for (int i = 0; i < int'(N_STAGES); i++) begin
            stage_start[i] = (state == START) && (idx == IDX_W'(i));
        end
    end

    assign stage_in = acc;
    assign busy     = (state != IDLE);
    assign mult_a   = (state == WAIT) ? cur_a : '0;
    assign mult_b   = (state == WAIT) ? cur_b : '0;

    shared_mult u_mult (
        .clk (clk),
        .rst (rst),
        .a   (mult_a),
        .b   (mult_b),
        .p   (mult_p)
    );

`ifdef DSP_SEQ_WATCHDOG_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] wd_cnt;

    // Counts cycles spent waiting on the current stage; abandon it at TIMEOUT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt <= '0;
            fault  <= 1'b0;
        end else begin
            wd_cnt <= (state == WAIT) ? wd_cnt + CNT_W'(1) : '0;
            if (timeout_c) fault <= 1'b1;
        end
    end

    assign timeout_c = (state == WAIT) && !cur_fin && (wd_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign timeout_c = 1'b0;
    assign fault     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= '0;
            acc          <= '0;
            skip         <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            acc          <= acc_nx;
            skip         <= skip_nx;
            sample_out   <= out_nx;
            sample_valid <= valid_nx;
            overrun      <= overrun_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        idx_nx     = idx;
        acc_nx     = acc;
        skip_nx    = skip;
        out_nx     = sample_t'(sample_out);
        valid_nx   = 1'b0;
        overrun_nx = overrun || (sample_tick && state != IDLE);
        first_c    = next_stage(bypass, 0);
        adv_c      = next_stage(skip, int'(idx) + 1);

        case (state)
            IDLE: begin
                if (sample_tick) begin
                    acc_nx  = sample_t'(sample_in);
                    skip_nx = bypass;
                    idx_nx  = first_c;
                    if (first_c == IDX_W'(N_STAGES)) begin
                        out_nx   = sample_t'(sample_in);
                        valid_nx = 1'b1;
                    end else begin
                        state_nx = START;
                    end
                end
            end
            START: state_nx = WAIT;
            WAIT: begin
                // A timed-out stage is treated as a finish that leaves acc untouched.
                if (cur_fin || timeout_c) begin
                    if (cur_fin) acc_nx = cur_out;
                    idx_nx = adv_c;
                    if (adv_c == IDX_W'(N_STAGES)) begin
                        out_nx   = cur_fin ? cur_out : acc;
                        valid_nx = 1'b1;
                        state_nx = IDLE;
                    end else begin
                        state_nx = START;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
